// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned RES_W  = 32;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned TAG_W  = 2;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_MOD = 4'd1;
  localparam logic [OP_W-1:0] OP_DIV = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL = 4'd4;
  localparam logic [OP_W-1:0] OP_SUB = 4'd8;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
  localparam logic [ERR_W-1:0] ERR_OVF     = 2'b01;
  localparam logic [ERR_W-1:0] ERR_DIV0    = 2'b10;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  // One queued command: operands, op code and its sequence tag.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } cmd_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_MOD) || (op == OP_DIV) ||
           (op == OP_MUL) || (op == OP_SUB);
  endfunction

  // Error code with priority illegal > divide-by-zero > overflow.
  function automatic logic [ERR_W-1:0] err_code(input logic [OP_W-1:0] op,
                                                input logic             b_zero,
                                                input logic             ovf);
    if (!is_legal_op(op))                               return ERR_ILLEGAL;
    else if (((op == OP_MOD) || (op == OP_DIV)) && b_zero) return ERR_DIV0;
    else if (((op == OP_ADD) || (op == OP_SUB)) && ovf)    return ERR_OVF;
    else                                                return ERR_NONE;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO; full/empty come from an occupancy count, pointers wrap modulo DEPTH.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives them to an external ALU, waits for settling and returns tagged responses.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [RES_W-1:0]  alu_r,
  input  logic              alu_error,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [ERR_W-1:0]  rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           state;
  state_t           state_next;
  cmd_t             head;
  cmd_t             wr_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             load_settle;
  logic             capture;
  logic             release_rsp;
  logic [TAG_W-1:0] tag_cnt;
  logic [TAG_W-1:0] cur_tag;
  logic [SET_W-1:0] settle_cnt;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign wr_cmd    = '{tag: tag_cnt, op: cmd_op, b: cmd_b, a: cmd_a};
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (!fifo_empty) state_next = ST_DRIVE;
      ST_DRIVE:   state_next = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == '0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    if (rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath.
  always_comb begin
    pop         = 1'b0;
    load_settle = 1'b0;
    capture     = 1'b0;
    release_rsp = 1'b0;
    unique case (state)
      ST_IDLE:    pop         = !fifo_empty;
      ST_DRIVE:   load_settle = 1'b1;
      ST_CAPTURE: capture     = 1'b1;
      ST_HOLD:    release_rsp = rsp_ready;
      default:    pop         = 1'b0;
    endcase
  end

  // Operand, settle, tag and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_cnt    <= '0;
      cur_tag    <= '0;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= ERR_NONE;
      rsp_tag    <= '0;
    end else begin
      if (push) tag_cnt <= tag_cnt + TAG_W'(1);
      if (pop) begin
        alu_a   <= head.a;
        alu_b   <= head.b;
        alu_op  <= head.op;
        cur_tag <= head.tag;
      end
      if (load_settle)                                 settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
      else if (state == ST_SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= is_legal_op(alu_op) ? alu_r : '0;
        rsp_err    <= err_code(alu_op, (alu_b == '0), alu_error);
        rsp_tag    <= cur_tag;
      end else if (release_rsp) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

endmodule
